sargantana_icache_way_ctrl: RTL and testbench

SARGANTANA_ICACHE_WAY_CTRL -- requirements
Module: sargantana_icache_way_ctrl

---
 rtl/sargantana_icache_pkg.sv | 14 +
 rtl/sargantana_icache_way_ctrl.sv | 111 +++++++++++
 tb/tb_sargantana_icache_way_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared widths and state encoding for the icache way controller.
// Imported by the way controller and its parent.
package sargantana_icache_pkg;

  localparam int unsigned ADDR_WIDHT = 8;
  localparam int unsigned SET_WIDHT  = 128;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    FLUSH = 2'd2
  } way_state_e;

endpackage

// File: rtl/sargantana_icache_way_ctrl.sv
// Way SRAM controller: init/flush zero sweep, refill/lookup
// arbitration with anti-starvation, registered SRAM command.
module sargantana_icache_way_ctrl #(
  parameter int unsigned ADDR_WIDHT =
    sargantana_icache_pkg::ADDR_WIDHT,
  parameter int unsigned SET_WIDHT =
    sargantana_icache_pkg::SET_WIDHT,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  lkp_req_i,
  input  logic [ADDR_WIDHT-1:0] lkp_addr_i,
  output logic                  lkp_gnt_o,
  output logic                  lkp_valid_o,
  output logic [SET_WIDHT-1:0]  lkp_data_o,
  input  logic                  rfl_req_i,
  input  logic [ADDR_WIDHT-1:0] rfl_addr_i,
  input  logic [SET_WIDHT-1:0]  rfl_data_i,
  output logic                  rfl_gnt_o,
  output logic                  busy_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDHT-1:0] sram_addr_o,
  output logic [SET_WIDHT-1:0]  sram_data_o,
  input  logic [SET_WIDHT-1:0]  sram_data_i
);
  import sargantana_icache_pkg::*;

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [ADDR_WIDHT-1:0] LAST = '1;

  way_state_e state_q, state_d;
  logic [ADDR_WIDHT-1:0] sweep_q;
  logic [SW-1:0]         starve_q;
  logic                  rd_pend_q;
  logic                  lkp_valid_q;
  logic                  starved;

  assign starved = (starve_q == STARVE_TOP);
  assign busy_o  = (state_q != READY);

  always_comb begin
    state_d   = state_q;
    lkp_gnt_o = 1'b0;
    rfl_gnt_o = 1'b0;
    unique case (state_q)
      INIT, FLUSH: begin
        if (sweep_q == LAST) state_d = READY;
      end
      READY: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else begin
          // Refill wins unless lookup has waited too long
          lkp_gnt_o = lkp_req_i &
                      (~rfl_req_i | starved);
          rfl_gnt_o = rfl_req_i & ~lkp_gnt_o;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      starve_q    <= '0;
      rd_pend_q   <= 1'b0;
      lkp_valid_q <= 1'b0;
      sram_req_o  <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= lkp_gnt_o;
      lkp_valid_q <= rd_pend_q;
      if (lkp_gnt_o) begin
        starve_q <= '0;
      end else if (lkp_req_i && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
      sram_req_o  <= 1'b0;
      sram_we_o   <= 1'b0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
      if (busy_o) begin
        sram_req_o  <= 1'b1;
        sram_we_o   <= 1'b1;
        sram_addr_o <= sweep_q;
        sweep_q     <= sweep_q + 1'b1;
      end else if (lkp_gnt_o) begin
        sram_req_o  <= 1'b1;
        sram_addr_o <= lkp_addr_i;
      end else if (rfl_gnt_o) begin
        sram_req_o  <= 1'b1;
        sram_we_o   <= 1'b1;
        sram_addr_o <= rfl_addr_i;
        sram_data_o <= rfl_data_i;
      end
    end
  end

  assign lkp_valid_o = lkp_valid_q;
  assign lkp_data_o  = lkp_valid_q ? sram_data_i : '0;

endmodule

// File: tb/tb_sargantana_icache_way_ctrl.sv
// Bench for the icache way controller: SRAM fixture plus a
// transaction-level reference of arbitration, sweeps and reads.
module tb_sargantana_icache_way_ctrl;
  import sargantana_icache_pkg::*;

  localparam int SMAX = 8;

  logic         clk, rstn, flush;
  logic         lkp_req, lkp_gnt, lkp_valid;
  logic [7:0]   lkp_addr;
  logic [127:0] lkp_data;
  logic         rfl_req, rfl_gnt;
  logic [7:0]   rfl_addr;
  logic [127:0] rfl_data;
  logic         busy, sram_req, sram_we;
  logic [7:0]   sram_addr;
  logic [127:0] sram_wdata, sram_rdata;

  sargantana_icache_way_ctrl #(.STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .lkp_req_i(lkp_req), .lkp_addr_i(lkp_addr),
    .lkp_gnt_o(lkp_gnt), .lkp_valid_o(lkp_valid),
    .lkp_data_o(lkp_data),
    .rfl_req_i(rfl_req), .rfl_addr_i(rfl_addr),
    .rfl_data_i(rfl_data), .rfl_gnt_o(rfl_gnt),
    .busy_o(busy), .sram_req_o(sram_req),
    .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_data_o(sram_wdata), .sram_data_i(sram_rdata)
  );

  always #5 clk = ~clk;

  // Way SRAM fixture: read data one cycle after a read command
  logic [127:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else sram_rdata <= sram_mem[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [127:0] m_mem [256];
  bit           m_sweep;
  int           m_addr;
  int           m_starve;
  bit           m_rd_pend;
  logic [127:0] m_rd_data;

  logic e_lg, e_rg, e_busy, e_sreq, e_swe, e_lv;
  logic [7:0]   e_saddr;
  logic [127:0] e_sdata, e_ld;

  logic lg, rg, o_busy, o_sreq, o_swe, o_lv;
  logic [7:0]   o_saddr;
  logic [127:0] o_sdata, o_ld;

  task automatic model_reset();
    m_sweep   = 1;
    m_addr    = 0;
    m_starve  = 0;
    m_rd_pend = 0;
    m_rd_data = '0;
  endtask

  // One clock: drive at negedge, sample grants, then sample
  // registered outputs just after the posedge.
  task automatic cycle(input logic lr, input logic [7:0] la,
                       input logic rr, input logic [7:0] ra,
                       input logic [127:0] rd, input logic fl);
    lkp_req = lr; lkp_addr = la;
    rfl_req = rr; rfl_addr = ra; rfl_data = rd;
    flush = fl;
    e_lg = 0; e_rg = 0;
    if (!m_sweep && !fl) begin
      if (lr && (!rr || m_starve == SMAX)) e_lg = 1;
      else e_rg = rr;
    end
    if (e_lg) m_starve = 0;
    else if (lr && m_starve < SMAX) m_starve++;
    e_lv = m_rd_pend;
    e_ld = m_rd_pend ? m_rd_data : '0;
    m_rd_pend = e_lg;
    m_rd_data = m_mem[la];
    e_sreq = 0; e_swe = 0; e_saddr = '0; e_sdata = '0;
    if (m_sweep) begin
      e_sreq = 1; e_swe = 1; e_saddr = 8'(m_addr);
      m_mem[m_addr] = '0;
      if (m_addr == 255) begin
        m_sweep = 0; m_addr = 0;
      end else m_addr++;
    end else if (fl) begin
      m_sweep = 1; m_addr = 0;
    end else if (e_lg) begin
      e_sreq = 1; e_saddr = la;
    end else if (e_rg) begin
      e_sreq = 1; e_swe = 1; e_saddr = ra; e_sdata = rd;
      m_mem[ra] = rd;
    end
    e_busy = m_sweep;
    #1;
    lg = lkp_gnt; rg = rfl_gnt;
    @(posedge clk); #1;
    o_busy = busy; o_sreq = sram_req; o_swe = sram_we;
    o_saddr = sram_addr; o_sdata = sram_wdata;
    o_lv = lkp_valid; o_ld = lkp_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 0; lkp_req = 1; rfl_req = 1; flush = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, sram_req, sram_we, lkp_valid, lkp_gnt, rfl_gnt}
        !== 6'b100000 || sram_addr !== 8'h0 ||
        sram_wdata !== '0 || lkp_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b req=%b we=%b lv=%b gnt=%b%b addr=%h, need 1 0 0 0 00 00",
               busy, sram_req, sram_we, lkp_valid, lkp_gnt,
               rfl_gnt, sram_addr);
    end
    lkp_req = 0; rfl_req = 0; flush = 0;
    @(negedge clk);
    rstn = 1;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(0, 8'h0, 0, 8'h0, '0, 0);
      checks++;
      if (o_sreq !== 1 || o_swe !== 1 || o_saddr !== 8'(i) ||
          o_sdata !== '0 || o_busy !== (i < 255)) begin
        errors++;
        $display("FAIL init_sweep %0d: req=%b we=%b addr=%h busy=%b, need 1 1 %h %b",
                 i, o_sreq, o_swe, o_saddr, o_busy, 8'(i), i < 255);
      end
    end
  endtask

  task automatic test_refill_lookup();
    logic [127:0] pat;
    pat = {16{8'hA5}};
    cycle(0, 8'h0, 1, 8'h12, pat, 0);
    checks++;
    if (rg !== 1 || lg !== 0 || o_sreq !== 1 || o_swe !== 1 ||
        o_saddr !== 8'h12 || o_sdata !== pat) begin
      errors++;
      $display("FAIL refill_cmd: gnt=%b req=%b we=%b addr=%h, need 1 1 1 12",
               rg, o_sreq, o_swe, o_saddr);
    end
    cycle(0, 8'h0, 0, 8'h0, '0, 0);
    cycle(1, 8'h12, 0, 8'h0, '0, 0);
    checks++;
    if (lg !== 1 || o_sreq !== 1 || o_swe !== 0 ||
        o_saddr !== 8'h12 || o_lv !== 0) begin
      errors++;
      $display("FAIL lookup_cmd: gnt=%b req=%b we=%b addr=%h lv=%b, need 1 1 0 12 0",
               lg, o_sreq, o_swe, o_saddr, o_lv);
    end
    cycle(0, 8'h0, 0, 8'h0, '0, 0);
    checks++;
    if (o_lv !== 1 || o_ld !== pat) begin
      errors++;
      $display("FAIL lookup_rsp: lv=%b data=%h, need 1 %h",
               o_lv, o_ld, pat);
    end
    cycle(0, 8'h0, 0, 8'h0, '0, 0);
    checks++;
    if (o_lv !== 0 || o_ld !== '0 || o_sreq !== 0) begin
      errors++;
      $display("FAIL lookup_idle: lv=%b data=%h req=%b, need 0 0 0",
               o_lv, o_ld, o_sreq);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'($urandom_range(0, 255)), 0, 8'h0, '0, 0);
      checks++;
      if (lg !== 1 || o_sreq !== e_sreq || o_saddr !== e_saddr ||
          o_lv !== (i >= 1) || o_ld !== e_ld) begin
        errors++;
        $display("FAIL b2b %0d: gnt=%b req=%b addr=%h lv=%b, need 1 %b %h %b",
                 i, lg, o_sreq, o_saddr, o_lv, e_sreq, e_saddr,
                 i >= 1);
      end
    end
  endtask

  task automatic test_contention();
    int ngnt;
    ngnt = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1, 8'($urandom_range(0, 255)), 1,
            8'($urandom_range(32, 255)),
            {$urandom, $urandom, $urandom, $urandom}, 0);
      if (lg === 1) ngnt++;
      checks++;
      if (lg !== ((i % 9) == 8) || rg !== ((i % 9) != 8) ||
          o_saddr !== e_saddr || o_swe !== e_swe ||
          o_lv !== e_lv || o_ld !== e_ld) begin
        errors++;
        $display("FAIL contention %0d: gnt=%b%b addr=%h we=%b lv=%b, need %b%b %h %b %b",
                 i, lg, rg, o_saddr, o_swe, o_lv,
                 (i % 9) == 8, (i % 9) != 8, e_saddr, e_swe, e_lv);
      end
    end
    checks++;
    if (ngnt != 4) begin
      errors++;
      $display("FAIL contention_count: grants=%0d, need 4", ngnt);
    end
  endtask

  task automatic test_flush_pending();
    logic [127:0] pat;
    pat = {16{8'hA5}};
    cycle(1, 8'h12, 0, 8'h0, '0, 0);
    cycle(1, 8'h12, 1, 8'h40, '1, 1);
    checks++;
    if (lg !== 0 || rg !== 0 || o_sreq !== 0 || o_busy !== 1 ||
        o_lv !== 1 || o_ld !== pat) begin
      errors++;
      $display("FAIL flush_pending: gnt=%b%b req=%b busy=%b lv=%b data=%h, need 00 0 1 1 %h",
               lg, rg, o_sreq, o_busy, o_lv, o_ld, pat);
    end
    for (int i = 0; i < 256; i++) begin
      cycle(1, 8'h12, 1, 8'h40, '1, i == 7);
      checks++;
      if (lg !== 0 || rg !== 0 || o_sreq !== 1 || o_swe !== 1 ||
          o_saddr !== 8'(i) || o_sdata !== '0 ||
          o_busy !== (i < 255)) begin
        errors++;
        $display("FAIL flush_sweep %0d: gnt=%b%b req=%b we=%b addr=%h busy=%b, need 00 1 1 %h %b",
                 i, lg, rg, o_sreq, o_swe, o_saddr, o_busy,
                 8'(i), i < 255);
      end
    end
    cycle(1, 8'h12, 0, 8'h0, '0, 0);
    cycle(0, 8'h0, 0, 8'h0, '0, 0);
    checks++;
    if (o_lv !== 1 || o_ld !== '0) begin
      errors++;
      $display("FAIL flush_readback: lv=%b data=%h, need 1 0",
               o_lv, o_ld);
    end
  endtask

  task automatic test_reset_mid_flush();
    cycle(0, 8'h0, 0, 8'h0, '0, 1);
    for (int i = 0; i <= 100; i++) cycle(0, 8'h0, 0, 8'h0, '0, 0);
    checks++;
    if (o_sreq !== 1 || o_saddr !== 8'd100) begin
      errors++;
      $display("FAIL pre_reset: req=%b addr=%h, need 1 64",
               o_sreq, o_saddr);
    end
    #1 rstn = 0;
    #1;
    checks++;
    if ({busy, sram_req, sram_we, lkp_valid} !== 4'b1000 ||
        sram_addr !== 8'h0 || sram_wdata !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b req=%b we=%b lv=%b addr=%h, need 1 0 0 0 00",
               busy, sram_req, sram_we, lkp_valid, sram_addr);
    end
    repeat (2) @(negedge clk);
    rstn = 1;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(0, 8'h0, 0, 8'h0, '0, 0);
      checks++;
      if (o_sreq !== 1 || o_swe !== 1 || o_saddr !== 8'(i) ||
          o_busy !== (i < 255)) begin
        errors++;
        $display("FAIL resweep %0d: req=%b we=%b addr=%h busy=%b, need 1 1 %h %b",
                 i, o_sreq, o_swe, o_saddr, o_busy, 8'(i), i < 255);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 149) == 0);
      checks++;
      if (lg !== e_lg || rg !== e_rg || o_busy !== e_busy ||
          o_sreq !== e_sreq || o_lv !== e_lv || o_ld !== e_ld ||
          (e_sreq && (o_saddr !== e_saddr || o_swe !== e_swe)) ||
          (e_sreq && e_swe && o_sdata !== e_sdata)) begin
        errors++;
        $display("FAIL random %0d: gnt=%b%b busy=%b req=%b we=%b addr=%h lv=%b ld=%h, need %b%b %b %b %b %h %b %h",
                 i, lg, rg, o_busy, o_sreq, o_swe, o_saddr, o_lv,
                 o_ld[31:0], e_lg, e_rg, e_busy, e_sreq, e_swe,
                 e_saddr, e_lv, e_ld[31:0]);
      end
    end
  endtask

  initial begin
    clk = 0; rstn = 0; flush = 0;
    lkp_req = 0; lkp_addr = '0;
    rfl_req = 0; rfl_addr = '0; rfl_data = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    model_reset();
    test_reset();
    test_refill_lookup();
    test_back_to_back();
    test_contention();
    test_flush_pending();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
